// File: rtl/reg_read_unit_pkg.sv
// ---------------------------------------------------------------------------
// reg_read_pkg
//   Shared definitions for the register-set read unit:
//     - default geometry of the register set (16 x 16-bit, 4-bit index)
//     - dump streamer FSM state encoding
//     - even-parity helper used when REG_READ_PARITY_EN is defined
// ---------------------------------------------------------------------------
package reg_read_pkg;

    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } dump_state_t;

    // XOR reduction of a data word (1 when the word has an odd number of ones).
    function automatic logic even_parity(input logic [DEF_DATA_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/reg_read_unit_if.sv
// ---------------------------------------------------------------------------
// reg_read_unit_if
//   Bundles every non-clock/reset signal of reg_read_unit.
//   master modport: the environment (register set + datapath/debug side)
//   slave  modport: reg_read_unit itself
//
//   Signals:
//     regs_flat / regWrite / decOut / writeData : register set outputs and
//                                                 snooped write interface
//     rd_req_x / rd_addr_x -> rd_valid_x / rd_data_x : read ports A and B
//     dump_start / dump_ready -> dump_valid / dump_idx / dump_data /
//                                dump_busy / dump_done : dump streamer
//     dump_state : dump FSM state, exported for observation
//
//   Handshake: a dump beat transfers in every cycle where dump_valid and
//   dump_ready are both 1; while dump_valid=1 and dump_ready=0 the beat
//   (dump_idx, dump_data) is held unchanged. Read ports have no handshake:
//   a request always produces its result exactly one cycle later.
//
//   Optional macro REG_READ_PARITY_EN adds rd_par_a, rd_par_b, dump_par.
// ---------------------------------------------------------------------------
interface reg_read_unit_if
    import reg_read_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W
);

    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic                       regWrite;
    logic [NUM_REGS-1:0]        decOut;
    logic [DATA_W-1:0]          writeData;

    logic                       rd_req_a;
    logic [ADDR_W-1:0]          rd_addr_a;
    logic                       rd_valid_a;
    logic [DATA_W-1:0]          rd_data_a;

    logic                       rd_req_b;
    logic [ADDR_W-1:0]          rd_addr_b;
    logic                       rd_valid_b;
    logic [DATA_W-1:0]          rd_data_b;

    logic                       dump_start;
    logic                       dump_ready;
    logic                       dump_valid;
    logic [ADDR_W-1:0]          dump_idx;
    logic [DATA_W-1:0]          dump_data;
    logic                       dump_busy;
    logic                       dump_done;
    dump_state_t                dump_state;

`ifdef REG_READ_PARITY_EN
    logic                       rd_par_a;
    logic                       rd_par_b;
    logic                       dump_par;
`endif

    modport master (
        output regs_flat, regWrite, decOut, writeData,
        output rd_req_a, rd_addr_a, rd_req_b, rd_addr_b,
        output dump_start, dump_ready,
        input  rd_valid_a, rd_data_a, rd_valid_b, rd_data_b,
        input  dump_valid, dump_idx, dump_data, dump_busy, dump_done,
        input  dump_state
`ifdef REG_READ_PARITY_EN
        , input rd_par_a, rd_par_b, dump_par
`endif
    );

    modport slave (
        input  regs_flat, regWrite, decOut, writeData,
        input  rd_req_a, rd_addr_a, rd_req_b, rd_addr_b,
        input  dump_start, dump_ready,
        output rd_valid_a, rd_data_a, rd_valid_b, rd_data_b,
        output dump_valid, dump_idx, dump_data, dump_busy, dump_done,
        output dump_state
`ifdef REG_READ_PARITY_EN
        , output rd_par_a, rd_par_b, dump_par
`endif
    );

endinterface

// File: rtl/reg_read_unit_mux.sv
// ---------------------------------------------------------------------------
// reg_read_mux
//   Combinational "effective value" selector for one register index: the
//   stored register value, or the write data when the snooped write targets
//   that index in this cycle (multi-hot decOut bypasses every selected index).
//
//   Ports:
//     i_regs_flat   register set outputs, register i at [i*DATA_W +: DATA_W]
//     i_reg_write   snooped write enable
//     i_dec_out     snooped one-hot write select
//     i_write_data  snooped write data
//     i_idx         register index to look up
//     o_word        effective value of register i_idx
// ---------------------------------------------------------------------------
module reg_read_mux
    import reg_read_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic [NUM_REGS*DATA_W-1:0] i_regs_flat,
    input  logic                       i_reg_write,
    input  logic [NUM_REGS-1:0]        i_dec_out,
    input  logic [DATA_W-1:0]          i_write_data,
    input  logic [ADDR_W-1:0]          i_idx,
    output logic [DATA_W-1:0]          o_word
);

    logic [DATA_W-1:0] w_stored;

    always_comb begin
        w_stored = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_idx == ADDR_W'(i)) begin
                w_stored = i_regs_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    assign o_word = (i_reg_write && i_dec_out[i_idx]) ? i_write_data : w_stored;

endmodule

// File: rtl/reg_read_unit.sv
// ---------------------------------------------------------------------------
// reg_read_unit
//   Read-side companion to the register set: two independent registered
//   random-access read ports (1-cycle latency, no backpressure) and a serial
//   dump streamer that walks every register once with a valid/ready beat.
//   All lookups go through reg_read_mux so same-cycle writes are bypassed.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high; clears all outputs, FSM to IDLE,
//            abandons any dump in progress without a done pulse
//     bus    reg_read_unit_if.slave (see interface header for signals)
//
//   Optional macro REG_READ_PARITY_EN: registers even parity next to
//   rd_data_a, rd_data_b and dump_data.
// ---------------------------------------------------------------------------
module reg_read_unit
    import reg_read_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic           clk,
    input  logic           reset,
    reg_read_unit_if.slave bus
);

    logic [DATA_W-1:0] w_word_a;
    logic [DATA_W-1:0] w_word_b;
    logic [DATA_W-1:0] w_word_dump;
    logic [ADDR_W-1:0] w_dump_sel;

    logic              r_valid_a;
    logic [DATA_W-1:0] r_data_a;
    logic              r_valid_b;
    logic [DATA_W-1:0] r_data_b;

    dump_state_t       r_state;
    logic [ADDR_W-1:0] r_dump_idx;
    logic [DATA_W-1:0] r_dump_data;
    logic              r_dump_valid;
    logic              r_dump_busy;
    logic              r_dump_done;

`ifdef REG_READ_PARITY_EN
    logic              r_par_a;
    logic              r_par_b;
    logic              r_dump_par;
`endif

    // While idle the dump mux points at register 0 so the first beat can be
    // loaded on dump_start; while sending it points at the next index so the
    // following beat loads in the same cycle the current one is accepted.
    assign w_dump_sel = (r_state == SEND) ? (r_dump_idx + ADDR_W'(1)) : '0;

    reg_read_mux #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux_a (
        .i_regs_flat  (bus.regs_flat),
        .i_reg_write  (bus.regWrite),
        .i_dec_out    (bus.decOut),
        .i_write_data (bus.writeData),
        .i_idx        (bus.rd_addr_a),
        .o_word       (w_word_a)
    );

    reg_read_mux #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux_b (
        .i_regs_flat  (bus.regs_flat),
        .i_reg_write  (bus.regWrite),
        .i_dec_out    (bus.decOut),
        .i_write_data (bus.writeData),
        .i_idx        (bus.rd_addr_b),
        .o_word       (w_word_b)
    );

    reg_read_mux #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux_dump (
        .i_regs_flat  (bus.regs_flat),
        .i_reg_write  (bus.regWrite),
        .i_dec_out    (bus.decOut),
        .i_write_data (bus.writeData),
        .i_idx        (w_dump_sel),
        .o_word       (w_word_dump)
    );

    // Read ports: data only updates on a request, so it holds between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid_a <= 1'b0;
            r_data_a  <= '0;
            r_valid_b <= 1'b0;
            r_data_b  <= '0;
`ifdef REG_READ_PARITY_EN
            r_par_a   <= 1'b0;
            r_par_b   <= 1'b0;
`endif
        end else begin
            r_valid_a <= bus.rd_req_a;
            r_valid_b <= bus.rd_req_b;
            if (bus.rd_req_a) begin
                r_data_a <= w_word_a;
`ifdef REG_READ_PARITY_EN
                r_par_a  <= even_parity(w_word_a);
`endif
            end
            if (bus.rd_req_b) begin
                r_data_b <= w_word_b;
`ifdef REG_READ_PARITY_EN
                r_par_b  <= even_parity(w_word_b);
`endif
            end
        end
    end

    // Dump streamer. The beat register is a snapshot taken at load time, so
    // writes during a stall never disturb the pending beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_dump_idx   <= '0;
            r_dump_data  <= '0;
            r_dump_valid <= 1'b0;
            r_dump_busy  <= 1'b0;
            r_dump_done  <= 1'b0;
`ifdef REG_READ_PARITY_EN
            r_dump_par   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_dump_done <= 1'b0;
                    if (bus.dump_start) begin
                        r_state      <= SEND;
                        r_dump_idx   <= '0;
                        r_dump_data  <= w_word_dump;
                        r_dump_valid <= 1'b1;
                        r_dump_busy  <= 1'b1;
`ifdef REG_READ_PARITY_EN
                        r_dump_par   <= even_parity(w_word_dump);
`endif
                    end
                end
                SEND: begin
                    if (bus.dump_ready) begin
                        if (r_dump_idx == ADDR_W'(NUM_REGS - 1)) begin
                            r_state      <= DONE;
                            r_dump_valid <= 1'b0;
                            r_dump_busy  <= 1'b0;
                            r_dump_done  <= 1'b1;
                        end else begin
                            r_dump_idx   <= w_dump_sel;
                            r_dump_data  <= w_word_dump;
`ifdef REG_READ_PARITY_EN
                            r_dump_par   <= even_parity(w_word_dump);
`endif
                        end
                    end
                end
                DONE: begin
                    r_state     <= IDLE;
                    r_dump_done <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_dump_valid <= 1'b0;
                    r_dump_busy  <= 1'b0;
                    r_dump_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_valid_a = r_valid_a;
    assign bus.rd_data_a  = r_data_a;
    assign bus.rd_valid_b = r_valid_b;
    assign bus.rd_data_b  = r_data_b;
    assign bus.dump_valid = r_dump_valid;
    assign bus.dump_idx   = r_dump_idx;
    assign bus.dump_data  = r_dump_data;
    assign bus.dump_busy  = r_dump_busy;
    assign bus.dump_done  = r_dump_done;
    assign bus.dump_state = r_state;
`ifdef REG_READ_PARITY_EN
    assign bus.rd_par_a   = r_par_a;
    assign bus.rd_par_b   = r_par_b;
    assign bus.dump_par   = r_dump_par;
`endif

endmodule

// File: tb/tb_reg_read_unit.sv
// ---------------------------------------------------------------------------
// tb_reg_read_unit
//   Scoreboard bench for reg_read_unit. The driver pushes expected responses
//   (tagged with the cycle they must appear) computed from a register-array
//   model; a negedge monitor pops and compares whatever the DUT presents.
//   Optional macro REG_READ_PARITY_EN enables the parity checks.
// ---------------------------------------------------------------------------
module tb_reg_read_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_read_unit_if bus ();

    reg_read_unit dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // ---------------- model state ----------------
    logic [15:0] regs [16];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [47:0] exp_a_q [$];     // {cycle, data}
    logic [47:0] exp_b_q [$];
    logic [51:0] exp_dump_q [$];  // {cycle the beat first shows, idx, data}
    int          exp_done_q [$];  // cycle of the done pulse

    bit          m_busy = 0;
    bit          m_done_wait = 0;
    int          m_cur = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] eff(input int i);
        if (bus.regWrite && bus.decOut[i]) return bus.writeData;
        return regs[i];
    endfunction

    task automatic drive_regs();
        for (int i = 0; i < 16; i++) bus.regs_flat[i*16 +: 16] = regs[i];
    endtask

    task automatic idle_inputs();
        bus.regWrite   = 1'b0;
        bus.decOut     = '0;
        bus.writeData  = '0;
        bus.rd_req_a   = 1'b0;
        bus.rd_addr_a  = '0;
        bus.rd_req_b   = 1'b0;
        bus.rd_addr_b  = '0;
        bus.dump_start = 1'b0;
    endtask

    task automatic flush_model();
        exp_a_q.delete();
        exp_b_q.delete();
        exp_dump_q.delete();
        exp_done_q.delete();
        m_busy      = 0;
        m_done_wait = 0;
    endtask

    // One clock: predict from the inputs currently applied, clock, then let
    // the register set absorb any write and present its new contents.
    task automatic step();
        if (!rst) begin
            if (bus.rd_req_a) exp_a_q.push_back({32'(cyc + 1), eff(int'(bus.rd_addr_a))});
            if (bus.rd_req_b) exp_b_q.push_back({32'(cyc + 1), eff(int'(bus.rd_addr_b))});
            if (m_done_wait) begin
                m_done_wait = 0;
            end else if (!m_busy) begin
                if (bus.dump_start) begin
                    m_busy = 1;
                    m_cur  = 0;
                    exp_dump_q.push_back({32'(cyc + 1), 4'd0, eff(0)});
                end
            end else if (bus.dump_ready) begin
                if (m_cur == 15) begin
                    m_busy      = 0;
                    m_done_wait = 1;
                    exp_done_q.push_back(cyc + 1);
                end else begin
                    m_cur++;
                    exp_dump_q.push_back({32'(cyc + 1), 4'(m_cur), eff(m_cur)});
                end
            end
        end
        @(posedge clk);
        cyc++;
        if (bus.regWrite) begin
            for (int i = 0; i < 16; i++) if (bus.decOut[i]) regs[i] = bus.writeData;
        end
        #1;
        drive_regs();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_valid_a"}, 64'(bus.rd_valid_a), 0);
        chk({tag, "_rd_data_a"},  64'(bus.rd_data_a), 0);
        chk({tag, "_rd_valid_b"}, 64'(bus.rd_valid_b), 0);
        chk({tag, "_rd_data_b"},  64'(bus.rd_data_b), 0);
        chk({tag, "_dump_valid"}, 64'(bus.dump_valid), 0);
        chk({tag, "_dump_idx"},   64'(bus.dump_idx), 0);
        chk({tag, "_dump_data"},  64'(bus.dump_data), 0);
        chk({tag, "_dump_busy"},  64'(bus.dump_busy), 0);
        chk({tag, "_dump_done"},  64'(bus.dump_done), 0);
        chk({tag, "_dump_state"}, 64'(bus.dump_state), 0);
`ifdef REG_READ_PARITY_EN
        chk({tag, "_par"}, 64'({bus.rd_par_a, bus.rd_par_b, bus.dump_par}), 0);
`endif
    endtask

    // Called just after an edge: asserts reset between edges and checks the
    // outputs clear before the next edge arrives.
    task automatic async_reset_check(input string tag);
        #2;
        rst = 1'b1;
        flush_model();
        #1;
        check_all_zero(tag);
        step();
        rst = 1'b0;
    endtask

    task automatic run_dump_to_end();
        for (int k = 0; k < 60 && (m_busy || m_done_wait); k++) step();
        chk("dump_finished_in_budget", 64'(m_busy || m_done_wait), 0);
    endtask

    // ---------------- monitor ----------------
    logic mon_va, mon_vb, mon_vd, mon_dn;

    always @(negedge clk) begin
        if (!rst) begin
            mon_va = (exp_a_q.size() > 0) && (exp_a_q[0][47:16] == 32'(cyc));
            chk("rd_valid_a", 64'(bus.rd_valid_a), 64'(mon_va));
            if (mon_va) begin
                chk("rd_data_a", 64'(bus.rd_data_a), 64'(exp_a_q[0][15:0]));
`ifdef REG_READ_PARITY_EN
                chk("rd_par_a", 64'(bus.rd_par_a), 64'(^exp_a_q[0][15:0]));
`endif
                void'(exp_a_q.pop_front());
            end
            mon_vb = (exp_b_q.size() > 0) && (exp_b_q[0][47:16] == 32'(cyc));
            chk("rd_valid_b", 64'(bus.rd_valid_b), 64'(mon_vb));
            if (mon_vb) begin
                chk("rd_data_b", 64'(bus.rd_data_b), 64'(exp_b_q[0][15:0]));
`ifdef REG_READ_PARITY_EN
                chk("rd_par_b", 64'(bus.rd_par_b), 64'(^exp_b_q[0][15:0]));
`endif
                void'(exp_b_q.pop_front());
            end
            mon_vd = (exp_dump_q.size() > 0) && (exp_dump_q[0][51:20] <= 32'(cyc));
            chk("dump_valid", 64'(bus.dump_valid), 64'(mon_vd));
            chk("dump_busy", 64'(bus.dump_busy), 64'(mon_vd));
            if (mon_vd && bus.dump_valid) begin
                chk("dump_idx", 64'(bus.dump_idx), 64'(exp_dump_q[0][19:16]));
                chk("dump_data", 64'(bus.dump_data), 64'(exp_dump_q[0][15:0]));
`ifdef REG_READ_PARITY_EN
                chk("dump_par", 64'(bus.dump_par), 64'(^exp_dump_q[0][15:0]));
`endif
                if (bus.dump_ready) void'(exp_dump_q.pop_front());
            end
            mon_dn = (exp_done_q.size() > 0) && (exp_done_q[0] == cyc);
            chk("dump_done", 64'(bus.dump_done), 64'(mon_dn));
            if (mon_dn) void'(exp_done_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        bus.dump_ready = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
        drive_regs();

        // reset state
        step();
        #1;
        check_all_zero("reset");
        step();
        rst = 1'b0;
        step();

        // plain read: R5 = A5A5, valid for exactly one cycle
        regs[5] = 16'hA5A5;
        drive_regs();
        bus.rd_req_a  = 1'b1;
        bus.rd_addr_a = 4'd5;
        step();
        idle_inputs();
        step();
        step();

        // bypass on B, old value on A
        regs[3] = 16'h0001;
        regs[4] = 16'h4444;
        drive_regs();
        bus.regWrite  = 1'b1;
        bus.decOut    = 16'h0008;
        bus.writeData = 16'hBEEF;
        bus.rd_req_b  = 1'b1;
        bus.rd_addr_b = 4'd3;
        bus.rd_req_a  = 1'b1;
        bus.rd_addr_a = 4'd4;
        step();
        // same address on both ports, back to back
        idle_inputs();
        bus.rd_req_a  = 1'b1;
        bus.rd_addr_a = 4'd3;
        bus.rd_req_b  = 1'b1;
        bus.rd_addr_b = 4'd3;
        step();
        idle_inputs();
        step();

        // asynchronous reset mid-simulation (read data registers are nonzero)
        async_reset_check("async_reset");
        step();

        // full-rate dump
        for (int i = 0; i < 16; i++) regs[i] = 16'h1000 + 16'(i);
        drive_regs();
        bus.dump_ready = 1'b1;
        bus.dump_start = 1'b1;
        step();
        bus.dump_start = 1'b0;
        run_dump_to_end();
        step();

        // backpressure at idx 7 with a write to R7 and ignored starts
        bus.dump_start = 1'b1;
        step();
        bus.dump_start = 1'b0;
        for (int k = 0; k < 20 && m_cur != 7; k++) step();
        bus.dump_ready = 1'b0;
        bus.dump_start = 1'b1;
        bus.regWrite   = 1'b1;
        bus.decOut     = 16'h0080;
        bus.writeData  = 16'hFFFF;
        step();
        bus.regWrite   = 1'b0;
        bus.decOut     = '0;
        step();
        step();
        bus.dump_start = 1'b0;
        bus.dump_ready = 1'b1;
        run_dump_to_end();
        step();

        // reset mid-dump at idx 9, then restart from idx 0
        for (int i = 0; i < 16; i++) regs[i] = 16'h2000 + 16'(i);
        drive_regs();
        bus.dump_start = 1'b1;
        step();
        bus.dump_start = 1'b0;
        for (int k = 0; k < 20 && m_cur != 9; k++) step();
        async_reset_check("mid_dump_reset");
        for (int k = 0; k < 3; k++) step();
        bus.dump_start = 1'b1;
        step();
        bus.dump_start = 1'b0;
        run_dump_to_end();
        step();

        // randomized traffic on all three channels
        for (int n = 0; n < 600; n++) begin
            bus.rd_req_a   = 1'($urandom_range(0, 1));
            bus.rd_addr_a  = 4'($urandom_range(0, 15));
            bus.rd_req_b   = 1'($urandom_range(0, 1));
            bus.rd_addr_b  = 4'($urandom_range(0, 15));
            bus.regWrite   = ($urandom_range(0, 2) == 0);
            bus.decOut     = ($urandom_range(0, 3) == 0) ? 16'($urandom) : (16'h1 << $urandom_range(0, 15));
            bus.writeData  = 16'($urandom);
            bus.dump_start = ($urandom_range(0, 9) == 0);
            bus.dump_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        // drain
        idle_inputs();
        bus.dump_ready = 1'b1;
        run_dump_to_end();
        for (int k = 0; k < 4; k++) step();
        chk("exp_a_drained", 64'(exp_a_q.size()), 0);
        chk("exp_b_drained", 64'(exp_b_q.size()), 0);
        chk("exp_dump_drained", 64'(exp_dump_q.size()), 0);
        chk("exp_done_drained", 64'(exp_done_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
